trans_pingpong_mb: RTL
======================

Name: trans_pingpong_mb

Overview:
- Two-bank ping-pong transpose buffer with a parametrised lane count.
- The write side fills one bank while the read side drains the other, so fill and drain overlap fully instead of alternating through a single memory.
- Per-lane write enables replace fixed rank-mode packing.
- Per-bank read counts are latched, so each bank is re-read (reused) its own number of times.

Parameters:
- DAT_WIDTH, 16, bits per lane
- LANES, 4, lanes per memory word; word width W = LANES*DAT_WIDTH
- MEM_DEPTH, 16, words per bank
- log2_MEM_DEPTH, 4, clog2(MEM_DEPTH)
- RCNT_W, 7, width of the read-beat count per bank fill

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- wr_vld  in  1  write beat valid
- wr_rdy  out  1  current write bank not full
- waddr  in  log2_MEM_DEPTH  write word address
- wdata  in  W  write data, lane i = bits [i*DAT_WIDTH +: DAT_WIDTH]
- wr_lane_en  in  LANES  per-lane write enable
- waddr_max  in  log2_MEM_DEPTH+1  words per fill, 1..MEM_DEPTH
- rd_vld  in  1  read request
- rd_rdy  out  1  current read bank full
- raddr  in  log2_MEM_DEPTH  read word address
- raddr_max  in  RCNT_W  read beats per fill, >=1
- rdata  out  W  registered read data
- rd_dat_out_vld  out  1  rdata valid strobe
- wr_bank  out  1  bank currently written
- rd_bank  out  1  bank currently read
- bank_full  out  2  per-bank full flags
- err  out  1  sticky error (see Optional Feature)

Behaviour:
- Storage: mem[2][MEM_DEPTH] of W bits. Not reset; contents are undefined until written.
- Reset (async, rst=1): wr_bank=0, rd_bank=0, bank_full=00, rd_cnt=0, rdata=0, rd_dat_out_vld=0, err=0. A reset mid-fill or mid-drain discards all progress.
- Ready outputs (combinational):
  - wr_rdy = !bank_full[wr_bank]
  - rd_rdy = bank_full[rd_bank]
- Write beat (wr_vld&wr_rdy):
  - For each lane i with wr_lane_en[i]=1, write lane i of mem[wr_bank][waddr].
  - Disabled lanes hold their old value.
- Fill complete:
  - Condition: a write beat with waddr == waddr_max-1, compared at log2_MEM_DEPTH+1 bits.
  - Next cycle: bank_full[wr_bank]=1, wr_bank toggles, and rmax[wr_bank] <= raddr_max (latched).
  - Completion is by address match, not by beat count: out-of-order writes are legal, but the fill ends on the last address.
- Read beat (rd_vld&rd_rdy):
  - rdata <= all W bits of mem[rd_bank][raddr].
  - rd_dat_out_vld=1 exactly one cycle later.
  - rd_cnt increments.
  - rdata holds its value when no beat occurs.
- Drain complete:
  - Condition: a read beat with rd_cnt == rmax[rd_bank]-1.
  - Next cycle: bank_full[rd_bank]=0, rd_bank toggles, rd_cnt=0.
  - The data of that last beat is still delivered normally.
- Simultaneous fill-complete and drain-complete:
  - Both always refer to different banks (a full write bank blocks writes), so both take effect in the same cycle.
  - Write into a bank freed this cycle starts the following cycle.
- Both banks full: wr_rdy=0 until a drain completes.
- Both banks empty: rd_rdy=0. Read requests are ignored, with no rdata change and no strobe.
- Throughput:
  - One write and one read per cycle are sustained concurrently.
  - Back-to-back fills are stalled only by the drain.
  - Back-to-back drains: rd_rdy is high again in the cycle after drain-complete if the other bank is full.
- Configuration stability:
  - waddr_max must be stable during a fill.
  - raddr_max is sampled only at fill-complete; changing it later does not affect that bank.
- Illegal settings:
  - waddr_max=0 or waddr_max>MEM_DEPTH: the bank never fills.
  - raddr_max=0: treated as 2^RCNT_W beats (counter wrap).

Optional Feature:
- Macro: TRANS_PINGPONG_ERR_EN.
- When defined, err is set sticky (cleared only by rst) on any of:
  - a write beat with waddr >= waddr_max; that beat is dropped, with no mem write and no fill-complete;
  - a fill-complete that latches raddr_max=0;
  - rd_vld=1 while rd_rdy=0 for more than 255 consecutive cycles (starvation watchdog, 8-bit counter reset on rd_rdy).
- When undefined:
  - err is tied 0;
  - out-of-range writes are performed;
  - no watchdog logic is generated.

Test Plan:
- Fill/drain: W=64, waddr_max=16, raddr_max=16; write 0..15 with wdata=addr*0x0101; read raddr 0..15 -> rdata matches each address, rd_dat_out_vld lags each read beat by 1 cycle, and bank_full goes 01 -> 00.
- Overlap: fill bank0, then fill bank1 while draining bank0 with continuous vld -> no stall on either side, rd_bank toggles on the cycle after the 16th read, and bank1 is read with no bubble.
- Lane mask: write addr 3 with 0xAAAA_BBBB_CCCC_DDDD, then addr 3 with 0x1111_2222_3333_4444 and wr_lane_en=0101 -> read returns 0xAAAA_2222_CCCC_4444.
- Reuse and latch: raddr_max=48, change input to 5 after fill-complete -> exactly 48 read beats are accepted before bank_full clears; both banks full gives wr_rdy=0 throughout.
- Reset mid-drain: assert rst after 7 of 16 reads -> all outputs return to reset values the same cycle and rd_rdy=0; after a refill, rd_cnt starts from 0.
- With TRANS_PINGPONG_ERR_EN: waddr_max=8, write waddr=12 -> err=1 and mem unchanged; without the macro -> err=0 and the word is written.

Source files
------------

// File: rtl/trans_pingpong_mb_if.sv
// Handshake and data bus of the ping-pong transpose buffer; master = producer/consumer side, slave = buffer.
// Width parameters must match the buffer instance that uses the slave modport.
interface trans_pingpong_mb_if #(
   parameter int DAT_WIDTH = 16,
   parameter int LANES     = 4,
   parameter int AW        = 4
);
   logic                       wr_vld;
   logic                       wr_rdy;
   logic [AW-1:0]              waddr;
   logic [LANES*DAT_WIDTH-1:0] wdata;
   logic [LANES-1:0]           wr_lane_en;
   logic                       rd_vld;
   logic                       rd_rdy;
   logic [AW-1:0]              raddr;
   logic [LANES*DAT_WIDTH-1:0] rdata;
   logic                       rd_dat_out_vld;

   modport master (
      output wr_vld, waddr, wdata, wr_lane_en, rd_vld, raddr,
      input  wr_rdy, rd_rdy, rdata, rd_dat_out_vld
   );

   modport slave (
      input  wr_vld, waddr, wdata, wr_lane_en, rd_vld, raddr,
      output wr_rdy, rd_rdy, rdata, rd_dat_out_vld
   );
endinterface

// File: rtl/trans_pingpong_mb.sv
// Two-bank ping-pong transpose buffer: fill one bank while the other drains; rdata 1 cycle after a read beat.
// Backpressure: wr_rdy low while the write bank is full, rd_rdy low until the read bank is full. Optional checks: TRANS_PINGPONG_ERR_EN.
module trans_pingpong_mb #(
   parameter int DAT_WIDTH      = 16,
   parameter int LANES          = 4,
   parameter int MEM_DEPTH      = 16,
   parameter int log2_MEM_DEPTH = 4,
   parameter int RCNT_W         = 7
) (
   input  logic                      clk,
   input  logic                      rst,
   trans_pingpong_mb_if.slave        bus,
   input  logic [log2_MEM_DEPTH:0]   waddr_max,
   input  logic [RCNT_W-1:0]         raddr_max,
   output logic                      wr_bank,
   output logic                      rd_bank,
   output logic [1:0]                bank_full,
   output logic                      err
);
   localparam int W  = LANES * DAT_WIDTH;
   localparam int AW = log2_MEM_DEPTH;

   logic [W-1:0]        mem [2][MEM_DEPTH];

   logic                wr_bank_q, wr_bank_d;
   logic                rd_bank_q, rd_bank_d;
   logic [1:0]          bank_full_q, bank_full_d;
   logic [RCNT_W-1:0]   rd_cnt_q, rd_cnt_d;
   logic [RCNT_W-1:0]   rmax_q [2];
   logic [RCNT_W-1:0]   rmax_d [2];
   logic [W-1:0]        rdata_q, rdata_d;
   logic                rd_out_vld_q, rd_out_vld_d;

   logic wr_rdy, rd_rdy, wr_fire, wr_do, rd_fire, fill_done, drain_done;

   assign wr_rdy     = !bank_full_q[wr_bank_q];
   assign rd_rdy     = bank_full_q[rd_bank_q];
   assign wr_fire    = bus.wr_vld && wr_rdy;
   assign rd_fire    = bus.rd_vld && rd_rdy;
   // Fill ends on the last address, so an illegal waddr_max simply never matches.
   assign fill_done  = wr_do && ({1'b0, bus.waddr} == (waddr_max - {{AW{1'b0}}, 1'b1}));
   assign drain_done = rd_fire && (rd_cnt_q == (rmax_q[rd_bank_q] - RCNT_W'(1)));

`ifdef TRANS_PINGPONG_ERR_EN
   logic       wr_oob, wd_hit, starve;
   logic       err_q, err_d;
   logic [7:0] wd_cnt_q, wd_cnt_d;

   assign wr_oob = ({1'b0, bus.waddr} >= waddr_max);
   assign wr_do  = wr_fire && !wr_oob;
   assign starve = bus.rd_vld && !rd_rdy;
   assign wd_hit = starve && (wd_cnt_q == 8'hFF);

   always_comb begin
      wd_cnt_d = 8'd0;
      if (starve) wd_cnt_d = (wd_cnt_q == 8'hFF) ? wd_cnt_q : wd_cnt_q + 8'd1;
      err_d = err_q | (wr_fire & wr_oob) | (fill_done & (raddr_max == '0)) | wd_hit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt_q <= 8'd0;
         err_q    <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         err_q    <= err_d;
      end
   end

   assign err = err_q;
`else
   assign wr_do = wr_fire;
   assign err   = 1'b0;
`endif

   always_comb begin
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      bank_full_d  = bank_full_q;
      rd_cnt_d     = rd_cnt_q;
      rmax_d       = rmax_q;
      rdata_d      = rdata_q;
      rd_out_vld_d = rd_fire;
      // Fill and drain always target different banks, so both updates can land together.
      if (fill_done) begin
         bank_full_d[wr_bank_q] = 1'b1;
         rmax_d[wr_bank_q]      = raddr_max;
         wr_bank_d              = !wr_bank_q;
      end
      if (rd_fire) begin
         rdata_d  = mem[rd_bank_q][bus.raddr];
         rd_cnt_d = rd_cnt_q + RCNT_W'(1);
      end
      if (drain_done) begin
         bank_full_d[rd_bank_q] = 1'b0;
         rd_bank_d              = !rd_bank_q;
         rd_cnt_d               = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         bank_full_q  <= 2'b00;
         rd_cnt_q     <= '0;
         rmax_q[0]    <= '0;
         rmax_q[1]    <= '0;
         rdata_q      <= '0;
         rd_out_vld_q <= 1'b0;
      end else begin
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         bank_full_q  <= bank_full_d;
         rd_cnt_q     <= rd_cnt_d;
         rmax_q       <= rmax_d;
         rdata_q      <= rdata_d;
         rd_out_vld_q <= rd_out_vld_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (wr_do && bus.wr_lane_en[i])
            mem[wr_bank_q][bus.waddr][i*DAT_WIDTH +: DAT_WIDTH] <= bus.wdata[i*DAT_WIDTH +: DAT_WIDTH];
      end
   end

   assign bus.wr_rdy         = wr_rdy;
   assign bus.rd_rdy         = rd_rdy;
   assign bus.rdata          = rdata_q;
   assign bus.rd_dat_out_vld = rd_out_vld_q;
   assign wr_bank            = wr_bank_q;
   assign rd_bank            = rd_bank_q;
   assign bank_full          = bank_full_q;
endmodule
